align_shift_register: RTL
=========================

Name: align_shift_register

Overview:
- Parametrised multi-cycle shift register for FPU mantissa alignment and normalisation.
- Loads an N-bit word, then shifts it a requested number of positions, one bit per enabled cycle, left or right.
- Right shifts are logical with serial fill, or arithmetic. A sticky/lost bit accumulates every bit shifted out; the FPU uses it for rounding on right shifts and overflow detection on left shifts.
- start/busy/done handshake to the FPU control FSM; successor to the single-step right-shift register.

Parameters:
N, 16, data width in bits (N >= 2)
SHW, 5, width of the shift-amount input; requested amounts above N are clamped to N

Ports:
clk    input   1    clock, all state updates on rising edge
rst    input   1    synchronous active-high reset
ena    input   1    global clock enable; low = full stall (all state held)
start  input   1    request new operation; sampled only in IDLE or DONE with ena=1
din    input   N    word loaded on accepted start
amt    input   SHW  shift amount, sampled on accepted start
dir    input   1    0 = shift right, 1 = shift left; sampled on accepted start
arith  input   1    right shift only: 1 = fill with MSB, 0 = fill with sin; sampled on accepted start
sin    input   1    serial fill bit, sampled every shift cycle (ignored when arith=1 on a right shift)
dout   output  N    shift register contents
sticky output  1    OR of all bits shifted out since last accepted start
busy   output  1    high in SHIFT state
done   output  1    one-cycle pulse in DONE state

Behaviour:
- Reset, synchronous, on a rising edge with rst=1:
  - State goes to IDLE.
  - dout=0, sticky=0, busy=0, done=0.
  - Internal counter and latched dir/arith go to 0.
  - Reset has priority over ena and start, and aborts any operation in flight.
- ena=0 holds everything: state, counter, dout, sticky, latched modes. done stays high if already in DONE.
- States:
  - IDLE: dout and sticky hold the last result.
  - SHIFT: one shift per ena cycle.
  - DONE: one cycle, then IDLE. If start is accepted in DONE, a new operation is loaded instead.
- Accepted start (ena=1, state IDLE or DONE, start=1):
  - dout <= din, sticky <= 0.
  - cnt <= min(amt, N); dir and arith are latched.
  - Next state is SHIFT if cnt > 0, else DONE.
- start in SHIFT is ignored with no side effects; it is not queued.
- Shift step in SHIFT with ena=1, using latched dir/arith:
  - Right: dout <= {fill, dout[N-1:1]}, where fill = dout[N-1] if arith else sin; sticky <= sticky | dout[0].
  - Left: dout <= {dout[N-2:0], sin}; sticky <= sticky | dout[N-1].
  - cnt <= cnt-1; when cnt==1 the next state is DONE.
- Latency: an operation accepted at edge k with clamped amount m has done high in the cycle following edge k+m, i.e. m+1 cycles after start. amt=0 gives 1 cycle.
- busy = (state==SHIFT); done = (state==DONE). Both are registered and glitch-free.
- Clamp: amt >= N performs exactly N shifts, so the word is fully replaced by fill. sticky = OR of all N original bits.
- Back-to-back operation: start held high with ena=1 gives one operation every m+1 cycles; no idle cycle is needed between operations.
- dout is valid when done=1 and remains stable through IDLE until the next accepted start.

Test Plan:
1. N=16, din=0xB4C3, amt=4, dir=0, arith=0, sin=0 -> busy for 4 cycles; done on 5th cycle after start; dout=0x0B4C, sticky=1.
2. din=0x8001, amt=3, dir=0, arith=1 -> dout=0xF000, sticky=1. Repeat with din=0x8000 -> dout=0xF000, sticky=0.
3. din=0x4001, amt=2, dir=1, sin=0 -> dout=0x0004, sticky=1. Then din=0x0000, amt=4, dir=0, arith=0, sin=1 -> dout=0xF000, sticky=0.
4. Boundaries:
   - amt=0, din=0x1234 -> done 1 cycle after start, dout=0x1234, sticky=0.
   - amt=20, din=0x0001, right logical, sin=0 -> 16 shifts, done 17 cycles after start, dout=0x0000, sticky=1.
5. Stall and interference on din=0xB4C3, amt=4:
   - ena=0 for 3 cycles mid-SHIFT -> dout/cnt frozen; done 3 cycles late; result still 0x0B4C.
   - start pulsed with din=0xFFFF during SHIFT -> ignored; result unchanged.
6. Reset and back-to-back:
   - rst=1 for one cycle during SHIFT -> next cycle IDLE, dout=0, sticky=0, busy=0, done=0.
   - start held high with amt=1 -> done pulses every 2 cycles, each result correct.

Source files
------------

// File: rtl/align_shift_register_if.sv
// Control/data bundle between the FPU control FSM and the alignment shift register.
// master = FPU control side, slave = shift register.
interface align_shift_register_if #(
  parameter int unsigned N   = 16,
  parameter int unsigned SHW = 5
) ();

  logic           ena;
  logic           start;
  logic [N-1:0]   din;
  logic [SHW-1:0] amt;
  logic           dir;
  logic           arith;
  logic           sin;
  logic [N-1:0]   dout;
  logic           sticky;
  logic           busy;
  logic           done;

  modport master (
    output ena, start, din, amt, dir, arith, sin,
    input  dout, sticky, busy, done
  );

  modport slave (
    input  ena, start, din, amt, dir, arith, sin,
    output dout, sticky, busy, done
  );

endinterface

// File: rtl/align_shift_register.sv
// Multi-cycle mantissa alignment/normalisation shifter: one bit per enabled
// cycle, left or right (logical/arithmetic), with a sticky bit over lost bits.
module align_shift_register #(
  parameter int unsigned N   = 16,
  parameter int unsigned SHW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  align_shift_register_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          sticky_q, sticky_d;
  logic          dir_q, dir_d;
  logic          arith_q, arith_d;
  logic          busy_q, done_q;

  logic [CW-1:0] amt_clamp_c;
  logic          fill_c;

  // Requested amounts beyond the word width collapse to a full-width shift.
  always_comb begin
    if (32'(bus.amt) > N) amt_clamp_c = CW'(N);
    else                  amt_clamp_c = CW'(bus.amt);
  end

  assign fill_c = arith_q ? dout_q[N-1] : bus.sin;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    sticky_d = sticky_q;
    dir_d    = dir_q;
    arith_d  = arith_q;

    if (bus.ena) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            dout_d   = bus.din;
            sticky_d = 1'b0;
            cnt_d    = amt_clamp_c;
            dir_d    = bus.dir;
            arith_d  = bus.arith;
            state_d  = (amt_clamp_c != '0) ? ST_SHIFT : ST_DONE;
          end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (dir_q) begin
            dout_d   = {dout_q[N-2:0], bus.sin};
            sticky_d = sticky_q | dout_q[N-1];
          end else begin
            dout_d   = {fill_c, dout_q[N-1:1]};
            sticky_d = sticky_q | dout_q[0];
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, datapath and status flags; busy/done are registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      sticky_q <= 1'b0;
      dir_q    <= 1'b0;
      arith_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      sticky_q <= sticky_d;
      dir_q    <= dir_d;
      arith_q  <= arith_d;
      busy_q   <= (state_d == ST_SHIFT);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign bus.dout   = dout_q;
  assign bus.sticky = sticky_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
